router_arbiter_wh_rr: RTL and testbench

// - N-input to 1-output wormhole arbiter for one NoC router output port.
// - Least-recently-granted matrix priority. Zero-cycle request-to-grant when unlocked.
// - Grant is held on the packet owner from head flit to tail flit.
// - Generalises the fixed 4-input arbiter:
//   - parametrised input count;
//   - registered owner index;
//   - grant driven (not suppressed) while locked;
//   - single-flit packet support;
//   - optional stall watchdog.
//

---
 rtl/router_arb_pkg.sv | 18 +
 rtl/router_arb_prio_matrix.sv | 45 ++++
 rtl/router_arbiter_wh_rr.sv | 114 +++++++++++
 tb/tb_router_arbiter_wh_rr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the wormhole round-robin output arbiter.
package router_arb_pkg;

  localparam int ARB_MAX_IN = 16;
  localparam int ARB_IDX_W  = $clog2(ARB_MAX_IN);

  // prio[i][j] = 1 means input i beats input j; unused rows/cols stay 0
  typedef logic [ARB_MAX_IN-1:0][ARB_MAX_IN-1:0] arb_prio_t;

  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_IN-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_IN; i++)
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/router_arb_prio_matrix.sv
// Least-recently-granted priority matrix: combinational winner, update on strobe.
module router_arb_prio_matrix
  import router_arb_pkg::*;
#(
  parameter int NUM_IN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] request,
  input  logic              update,
  output logic [NUM_IN-1:0] win_oh,
  output arb_prio_t         prio
);

  arb_prio_t prio_q;

  assign prio = prio_q;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_win
    logic beaten;
    always_comb begin
      beaten = 1'b0;
      for (int j = 0; j < NUM_IN; j++)
        if (j != gi && request[j] && prio_q[j][gi]) beaten = 1'b1;
      win_oh[gi] = request[gi] & ~beaten;
    end
  end

  // winner drops to lowest priority: its row cleared, its column set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARB_MAX_IN; i++)
        for (int j = 0; j < ARB_MAX_IN; j++)
          prio_q[i][j] <= (i < NUM_IN) && (j < NUM_IN) && (i < j);
    end else if (update) begin
      for (int i = 0; i < NUM_IN; i++)
        for (int j = 0; j < NUM_IN; j++)
          if (i != j) begin
            if (win_oh[i])      prio_q[i][j] <= 1'b0;
            else if (win_oh[j]) prio_q[i][j] <= 1'b1;
          end
    end
  end

endmodule

// File: rtl/router_arbiter_wh_rr.sv
// N-to-1 wormhole arbiter: LRG matrix priority, grant held from head to tail.
// Optional stall watchdog enabled by defining ROUTER_ARB_WATCHDOG_EN.
module router_arbiter_wh_rr
  import router_arb_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         request,
  input  logic                      forwarding_head,
  input  logic                      forwarding_tail,
  output logic [NUM_IN-1:0]         grant,
  output logic                      grant_valid,
  output logic                      locked,
  output logic [$clog2(NUM_IN)-1:0] owner_idx,
  output logic                      stall_timeout
);

  localparam int IDX_W = $clog2(NUM_IN);

  if (NUM_IN < 2 || NUM_IN > ARB_MAX_IN) begin : g_bad_num_in
    $error("NUM_IN out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end

  logic [NUM_IN-1:0] win_oh;
  arb_prio_t         prio;
  logic              locked_q;
  logic [IDX_W-1:0]  owner_q;
  logic [ARB_IDX_W-1:0] win_idx;
  logic              owner_req;
  logic              head_acc;
  logic              tail_acc;

  router_arb_prio_matrix #(.NUM_IN(NUM_IN)) u_prio (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .update  (head_acc),
    .win_oh  (win_oh),
    .prio    (prio)
  );

  assign win_idx   = onehot_to_idx(ARB_MAX_IN'(win_oh));
  assign owner_req = request[owner_q];
  assign head_acc  = forwarding_head & grant_valid & ~locked_q;
  assign tail_acc  = forwarding_tail & grant_valid & locked_q;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (locked_q) begin
      grant[owner_q] = 1'b1;
      grant_valid    = owner_req;
    end else begin
      grant       = win_oh;
      grant_valid = |request;
    end
  end

  // a head with tail in the same cycle is a single-flit packet and never locks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else if (head_acc) begin
      locked_q <= ~forwarding_tail;
      owner_q  <= win_idx[IDX_W-1:0];
    end else if (tail_acc) begin
      locked_q <= 1'b0;
    end
  end

  assign locked    = locked_q;
  assign owner_idx = owner_q;

`ifdef ROUTER_ARB_WATCHDOG_EN
  logic [15:0] stall_cnt;

  // counts locked cycles where the owner has nothing to send; observational only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       stall_cnt <= '0;
    else if (!locked_q || owner_req) stall_cnt <= '0;
    else if (stall_cnt != 16'(TIMEOUT)) stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_timeout = (stall_cnt == 16'(TIMEOUT));
`else
  assign stall_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
  function automatic logic prio_ok(input arb_prio_t p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < ARB_MAX_IN; i++)
      for (int j = 0; j < ARB_MAX_IN; j++)
        if (i < NUM_IN && j < NUM_IN && i != j) ok &= p[i][j] ^ p[j][i];
        else                                    ok &= ~p[i][j];
    return ok;
  endfunction

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
  a_prio_antisym:  assert property (@(posedge clk) disable iff (!rst) prio_ok(prio));
  a_no_head_lock:  assert property (@(posedge clk) disable iff (!rst) !(forwarding_head && locked_q));
  a_grant_stable:  assert property (@(posedge clk) disable iff (!rst)
                                    locked_q |=> (!locked_q || $stable(grant)));
`endif

endmodule

// File: tb/tb_router_arbiter_wh_rr.sv
// Scoreboarded bench for router_arbiter_wh_rr: LRU-list reference model, directed + random.
module tb_router_arbiter_wh_rr;

  localparam int N  = 5;
  localparam int TO = 4;

  typedef struct {
    logic [N-1:0] grant;
    logic         gv;
    logic         locked;
    logic [2:0]   owner;
    logic         stall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] request;
  logic         forwarding_head, forwarding_tail;
  logic [N-1:0] grant;
  logic         grant_valid, locked, stall_timeout;
  logic [2:0]   owner_idx;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // reference: priority as an ordered list, front = most preferred
  int order[$];
  bit m_locked;
  int m_owner;
  int m_cnt;

  router_arbiter_wh_rr #(.NUM_IN(N), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .request         (request),
    .forwarding_head (forwarding_head),
    .forwarding_tail (forwarding_tail),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .locked          (locked),
    .owner_idx       (owner_idx),
    .stall_timeout   (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    order = {0, 1, 2, 3, 4};
    m_locked = 1'b0;
    m_owner = 0;
    m_cnt = 0;
  endfunction

  // apply inputs now (posedge+1), push expected outputs, advance model across next edge
  task automatic cycle(input logic r, input logic [N-1:0] req, input logic fh, input logic ft);
    exp_t e;
    int w;
    bit own_req;
    rst = r;
    request = req;
    forwarding_head = fh;
    forwarding_tail = ft;
    if (!r) m_reset();
    w = -1;
    foreach (order[k]) if (w < 0 && req[order[k]]) w = order[k];
    own_req = req[m_owner];
    e.grant  = m_locked ? N'(1) << m_owner : (w >= 0 ? N'(1) << w : '0);
    e.gv     = m_locked ? own_req : |req;
    e.locked = m_locked;
    e.owner  = 3'(m_owner);
`ifdef ROUTER_ARB_WATCHDOG_EN
    e.stall  = (m_cnt == TO);
`else
    e.stall  = 1'b0;
`endif
    sb.push_back(e);
    if (r) begin
      if (!m_locked || own_req) m_cnt = 0;
      else if (m_cnt != TO) m_cnt++;
      if (!m_locked && fh && e.gv) begin
        m_owner = w;
        m_locked = !ft;
        foreach (order[k]) if (order[k] == w) begin order.delete(k); break; end
        order.push_back(w);
      end else if (m_locked && ft && e.gv) begin
        m_locked = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: compare against the queued expectation, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("grant",         32'(grant),         32'(e.grant));
        check("grant_valid",   32'(grant_valid),   32'(e.gv));
        check("locked",        32'(locked),        32'(e.locked));
        check("owner_idx",     32'(owner_idx),     32'(e.owner));
        check("stall_timeout", 32'(stall_timeout), 32'(e.stall));
      end
    end
  end

  initial begin
    rst = 1'b0;
    request = '0;
    forwarding_head = 1'b0;
    forwarding_tail = 1'b0;
    m_reset();
    #2;
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_owner",  32'(owner_idx), 32'd0);
    @(posedge clk);
    #1;
    cycle(1'b0, '0, 1'b0, 1'b0);

    // reset priority: lowest index requester wins combinationally
    rst = 1'b1;
    request = 5'b10110;
    #1;
    check("reset_prio_grant", 32'(grant), 32'h02);
    check("reset_prio_gv",    32'(grant_valid), 32'd1);
    cycle(1'b1, 5'b10110, 1'b0, 1'b0);

    // round robin: 3-flit packets, everyone requesting
    for (int p = 0; p < 6; p++) begin
      cycle(1'b1, 5'b11111, 1'b1, 1'b0);
      check("rr_owner", 32'(owner_idx), 32'(p % N));
      cycle(1'b1, 5'b11111, 1'b0, 1'b0);
      cycle(1'b1, 5'b11111, 1'b0, 1'b1);
    end

    // lock hold on input 2 while it idles and input 0 asks
    cycle(1'b1, 5'b00100, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      request = 5'b00001;
      #1;
      check("hold_grant", 32'(grant), 32'h04);
      check("hold_gv",    32'(grant_valid), 32'd0);
      cycle(1'b1, 5'b00001, 1'b0, 1'b0);
    end
    cycle(1'b1, 5'b00100, 1'b0, 1'b1);

    // single-flit packet on input 1 never locks and demotes it
    cycle(1'b1, 5'b00110, 1'b1, 1'b1);
    check("sf_locked", 32'(locked), 32'd0);
    request = 5'b00110;
    #1;
    check("sf_next_grant", 32'(grant), 32'h04);
    cycle(1'b1, 5'b00110, 1'b0, 1'b0);

    // async reset mid-packet on input 3
    cycle(1'b1, 5'b01000, 1'b1, 1'b0);
    check("ar_locked_before", 32'(locked), 32'd1);
    rst = 1'b0;
    #1;
    check("ar_locked", 32'(locked), 32'd0);
    check("ar_owner",  32'(owner_idx), 32'd0);
    cycle(1'b0, 5'b01000, 1'b0, 1'b0);
    request = 5'b11000;
    rst = 1'b1;
    #1;
    check("ar_grant", 32'(grant), 32'h08);
    cycle(1'b1, 5'b11000, 1'b0, 1'b0);

    // stalled owner on input 4
    cycle(1'b1, 5'b10000, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) cycle(1'b1, 5'b00000, 1'b0, 1'b0);
`ifdef ROUTER_ARB_WATCHDOG_EN
    check("wd_stall", 32'(stall_timeout), 32'd1);
`else
    check("wd_tied", 32'(stall_timeout), 32'd0);
`endif
    cycle(1'b1, 5'b10000, 1'b0, 1'b0);
    cycle(1'b1, 5'b10000, 1'b0, 1'b0);
    check("wd_clear", 32'(stall_timeout), 32'd0);
    cycle(1'b1, 5'b10000, 1'b0, 1'b1);

    // random traffic; heads only while unlocked
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] rq;
      logic fh, ft;
      rq = N'($urandom);
      if ($urandom_range(0, 3) == 0) rq = '0;
      fh = !m_locked && ($urandom_range(0, 1) == 1);
      ft = ($urandom_range(0, 2) == 0);
      cycle(($urandom_range(0, 99) != 0), rq, fh, ft);
    end
    cycle(1'b1, '0, 1'b0, 1'b0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
